posit_round_pipe: RTL and testbench
===================================

POSIT_ROUND_PIPE -- requirements
Module: posit_round_pipe

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning posit width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter ES, default 2, meaning exponent field width (0..4).
REQ-003 The block SHALL have parameter FW, default N, meaning input fraction width, hidden bit excluded, MSB-first.
REQ-004 The block SHALL have parameter RS, default $clog2(N), meaning the regime-value width is RS+2 bits signed.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed first:
  clk  in  1  clock, rising edge;
  rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have these data-path ports:
  in_valid  in  1  input beat valid;
  in_ready  out  1  block accepts the beat this cycle;
  in_sign  in  1  sign of the result;
  in_nar  in  1  result is NaR;
  in_zero  in  1  result is exact zero;
  in_k  in  RS+2  signed regime value;
  in_exp  in  ES  exponent field, unsigned;
  in_frac  in  FW  fraction bits below the hidden 1;
  in_sticky  in  1  OR of all discarded bits below in_frac;
  in_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RAZ, 11 reserved, treated as RNE;
  out_valid  out  1  output beat valid;
  out_ready  in  1  downstream accepts;
  out_posit  out  N  encoded posit, two's complement;
  out_inexact  out  1  rounding discarded non-zero bits;
  out_sat  out  1  result clamped to maxpos or minpos;
  cnt_clr  in  1  synchronous clear of inexact_cnt;
  inexact_cnt  out  16  saturating count of inexact beats delivered.

Function
REQ-007 Latency SHALL be exactly 2 cycles from input handshake to out_valid, with no bubbles under continuous flow.
  - Stage 1: build the unsigned magnitude (regime run, terminator, exponent, fraction) and shift it by the regime length.
  - Stage 2: extract L/G/R/S, round, clamp, and negate.
REQ-008 Throughput SHALL be 1 beat/cycle; in_ready = ~s2_valid | out_ready | ~s1_valid, so each stage advances when its successor is empty or advancing.
REQ-009 Output data SHALL stay stable while out_valid=1 and out_ready=0; the beat order SHALL be preserved.
REQ-010 Stage 1 SHALL form the magnitude field from MSB down:
  - regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1;
  - then in_exp, in_frac, 3 guard bits;
  - in_sticky is ORed into the S bit.
REQ-011 Rounding SHALL act on the top N-1 magnitude bits, with L = kept LSB, G = next bit, S = OR of all bits below G.
  - RNE: ulp = G&(S|L);
  - RTZ: ulp = 0;
  - RAZ: ulp = G|S.
REQ-012 out_inexact SHALL be G|S after shifting, independent of mode.
REQ-013 Saturation:
  - k > N-2, or a round-up overflowing 0x7F..F, SHALL give magnitude maxpos (0x7F..F) with out_sat=1;
  - k < -(N-2), or a rounded result of 0 from non-zero input, SHALL give minpos (0x00..1) with out_sat=1.
  - A finite non-zero input SHALL never produce 0 or NaR.
REQ-014 Exponent or fraction bits pushed past the N-1 window SHALL contribute only to G/S and SHALL NOT wrap.
REQ-015 When in_sign=1, out_posit SHALL be the two's complement of the rounded magnitude.
REQ-016 Special cases:
  - in_nar=1 SHALL give 1 followed by N-1 zeros, with out_inexact=0 and out_sat=0; in_nar SHALL take priority over in_zero;
  - in_zero=1 SHALL give all zeros with flags 0.
REQ-017 inexact_cnt SHALL increment on each out_valid&out_ready beat with out_inexact=1 and SHALL hold at 0xFFFF.
  - cnt_clr SHALL set it to 0 and take priority over a simultaneous increment.
REQ-018 in_mode SHALL be captured with the beat; a mode change mid-stream SHALL affect only later beats.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately clear both stage valids, out_valid, out_posit, out_inexact, out_sat and inexact_cnt to 0.
REQ-020 in_ready SHALL read 1 during reset, but no beat SHALL be accepted while rst_n=0.
REQ-021 Beats in flight at reset SHALL be discarded.
REQ-022 The first beat after deassertion SHALL emerge after exactly 2 cycles.

Verification (N=8, ES=0, FW=8)
REQ-023 The bench SHALL cover each of these directed scenarios:
  - k=0, exp none, frac=0x00, sticky=0, mode RNE -> 0x40, inexact=0, sat=0, 2 cycles after handshake;
  - k=0, frac=0x04 (tie), sign=0, each mode:
    - RNE -> 0x40;
    - RTZ -> 0x40;
    - RAZ -> 0x41;
    - inexact=1 in all three;
  - k=0, frac=0x80, sign=1 -> 0xB0 (-1.5); then k=7 -> 0x7F with sat=1; then k=-10 -> 0x01 with sat=1;
  - in_nar=1 with in_zero=1 -> 0x80; in_zero=1 only -> 0x00, flags 0;
  - 4 back-to-back beats with out_ready held low for 3 cycles:
    - out_posit is stable while stalled;
    - in_ready drops once both stages are full;
    - all 4 beats arrive in order;
    - inexact_cnt counts only the accepted inexact beats;
  - rst_n pulsed low while 2 beats are in flight -> out_valid=0 at once, inexact_cnt=0, and no stale beat appears afterwards.

Source files
------------

// File: rtl/posit_round_pipe.sv
// Two-stage posit rounding/encoding pipeline.
// Stage 1 assembles the unrounded magnitude (regime, exponent, fraction,
// guard bits) and left-aligns it according to the regime length.
// Stage 2 rounds on the top N-1 bits, clamps to maxpos/minpos, and applies
// the sign. A saturating counter tracks inexact beats delivered downstream.
module posit_round_pipe #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int FW = N,
    parameter int RS = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic                          in_nar,
    input  logic                          in_zero,
    input  logic [RS+1:0]                 in_k,
    input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
    input  logic [FW-1:0]                 in_frac,
    input  logic                          in_sticky,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  out_posit,
    output logic                          out_inexact,
    output logic                          out_sat,
    input  logic                          cnt_clr,
    output logic [15:0]                   inexact_cnt
);

    // body = exponent, fraction and three guard bits below the regime
    localparam int BW = ES + FW + 3;
    // room for the longest regime pattern (N ones/zeros plus terminator) above the body
    localparam int MW = N + 1 + BW;
    localparam int SW = $clog2(MW);

    logic [BW-1:0] body;

    generate
        if (ES > 0) begin : g_exp
            assign body = {in_exp[ES-1:0], in_frac, 3'b000};
        end else begin : g_noexp
            logic unused_exp;
            assign unused_exp = ^in_exp;
            assign body = {in_frac, 3'b000};
        end
    endgenerate

    // stage 1 registers
    logic          s1_valid;
    logic          s1_sign;
    logic          s1_nar;
    logic          s1_zero;
    logic          s1_hi;
    logic          s1_lo;
    logic [1:0]    s1_mode;
    logic [MW-1:0] s1_mag;

    // stage 2 is the output register
    logic          s2_valid;
    logic          s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign in_ready  = ~s2_valid | out_ready | ~s1_valid;
    assign out_valid = s2_valid;

    // stage 1 combinational: regime pattern + body, left-aligned by regime length
    int            k_val;
    int            sh_val;
    logic          k_hi;
    logic          k_lo;
    logic [SW-1:0] sh_amt;
    logic [MW-1:0] base;
    logic [MW-1:0] mag_shift;

    // Build the pattern with the full-length run on top, then shift the
    // unwanted run bits out of the MSB end so only the regime length remains.
    always_comb begin
        k_val  = int'($signed(in_k));
        k_hi   = (k_val > N - 2);
        k_lo   = (k_val < -(N - 2));
        sh_val = (k_val >= 0) ? (N - 1 - k_val) : (N + k_val);
        if (k_hi || k_lo) begin
            sh_val = 0;
        end
        sh_amt = SW'(sh_val);
        if (k_val >= 0) begin
            base = {{N{1'b1}}, 1'b0, body};
        end else begin
            base = {{N{1'b0}}, 1'b1, body};
        end
        mag_shift    = base << sh_amt;
        // bit 0 always lies below the guard position, so it can carry the sticky
        mag_shift[0] = mag_shift[0] | in_sticky;
    end

    // stage 1 register: accept a beat whenever in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_hi    <= 1'b0;
            s1_lo    <= 1'b0;
            s1_mode  <= 2'b00;
            s1_mag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_nar  <= in_nar;
                s1_zero <= in_zero;
                s1_hi   <= k_hi;
                s1_lo   <= k_lo;
                s1_mode <= in_mode;
                s1_mag  <= mag_shift;
            end
        end
    end

    // stage 2 combinational: L/G/S extraction, rounding, clamping, negation
    logic [N-2:0] kept;
    logic         g_bit;
    logic         s_bit;
    logic         ulp;
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic [N-1:0] pos;
    logic [N-1:0] nxt_posit;
    logic         nxt_inexact;
    logic         nxt_sat;

    // Rounding decision and final encoding of the stage-1 magnitude
    always_comb begin
        kept  = s1_mag[MW-1 -: N-1];
        g_bit = s1_mag[MW-N];
        s_bit = |s1_mag[MW-N-1:0];
        case (s1_mode)
            2'b01:   ulp = 1'b0;
            2'b10:   ulp = g_bit | s_bit;
            default: ulp = g_bit & (s_bit | kept[0]);
        endcase
        sum         = {1'b0, kept} + {{(N-1){1'b0}}, ulp};
        mag         = sum[N-2:0];
        nxt_inexact = g_bit | s_bit;
        nxt_sat     = 1'b0;
        if (s1_hi || sum[N-1]) begin
            mag     = {(N-1){1'b1}};
            nxt_sat = 1'b1;
        end else if (s1_lo || (sum == '0)) begin
            mag     = {{(N-2){1'b0}}, 1'b1};
            nxt_sat = 1'b1;
        end
        // out-of-range regime: the clamped value necessarily differs from the input
        if (s1_hi || s1_lo) begin
            nxt_inexact = 1'b1;
        end
        pos       = {1'b0, mag};
        nxt_posit = s1_sign ? (~pos + {{(N-1){1'b0}}, 1'b1}) : pos;
        if (s1_nar) begin
            nxt_posit   = {1'b1, {(N-1){1'b0}}};
            nxt_inexact = 1'b0;
            nxt_sat     = 1'b0;
        end else if (s1_zero) begin
            nxt_posit   = '0;
            nxt_inexact = 1'b0;
            nxt_sat     = 1'b0;
        end
    end

    // stage 2 register: advance when output is empty or being taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_posit   <= '0;
            out_inexact <= 1'b0;
            out_sat     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_posit   <= nxt_posit;
                out_inexact <= nxt_inexact;
                out_sat     <= nxt_sat;
            end
        end
    end

    // saturating count of inexact beats delivered; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inexact_cnt <= 16'd0;
        end else if (cnt_clr) begin
            inexact_cnt <= 16'd0;
        end else if (s2_valid && out_ready && out_inexact && (inexact_cnt != 16'hFFFF)) begin
            inexact_cnt <= inexact_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Scoreboard bench for posit_round_pipe at N=8, ES=0, FW=8.
module tb_posit_round_pipe;

    localparam int N  = 8;
    localparam int ES = 0;
    localparam int FW = 8;
    localparam int RS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic          in_nar = 1'b0;
    logic          in_zero = 1'b0;
    logic [RS+1:0] in_k = '0;
    logic [0:0]    in_exp = '0;
    logic [FW-1:0] in_frac = '0;
    logic          in_sticky = 1'b0;
    logic [1:0]    in_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_posit;
    logic          out_inexact;
    logic          out_sat;
    logic          cnt_clr = 1'b0;
    logic [15:0]   inexact_cnt;

    posit_round_pipe #(.N(N), .ES(ES), .FW(FW), .RS(RS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_nar      (in_nar),
        .in_zero     (in_zero),
        .in_k        (in_k),
        .in_exp      (in_exp),
        .in_frac     (in_frac),
        .in_sticky   (in_sticky),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_posit   (out_posit),
        .out_inexact (out_inexact),
        .out_sat     (out_sat),
        .cnt_clr     (cnt_clr),
        .inexact_cnt (inexact_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] posit;
        logic       inexact;
        logic       sat;
        logic       lat;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    logic lat_flag = 1'b0;
    logic k_in_range;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // bit-serial reference: write regime/fraction MSB-first, then round
    function automatic exp_t model(input logic sg, input logic nar, input logic zr, input int k,
                                   input logic [7:0] fr, input logic st, input logic [1:0] md);
        exp_t         r;
        logic [127:0] v;
        int           p;
        logic [6:0]   kept;
        logic [6:0]   mag;
        logic         g;
        logic         s;
        logic         ulp;
        logic [7:0]   sum;
        logic [7:0]   pos;
        r.lat = 1'b0;
        r.cyc = 0;
        r.inexact = 1'b0;
        r.sat = 1'b0;
        mag = 7'd0;
        if (nar) begin
            r.posit = 8'h80;
            return r;
        end
        if (zr) begin
            r.posit = 8'h00;
            return r;
        end
        if (k > N - 2) begin
            mag = 7'h7F;
            r.sat = 1'b1;
            r.inexact = 1'b1;
        end else if (k < -(N - 2)) begin
            mag = 7'h01;
            r.sat = 1'b1;
            r.inexact = 1'b1;
        end else begin
            v = '0;
            p = 127;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin v[p] = 1'b1; p--; end
                v[p] = 1'b0; p--;
            end else begin
                for (int i = 0; i < -k; i++) begin v[p] = 1'b0; p--; end
                v[p] = 1'b1; p--;
            end
            for (int i = FW - 1; i >= 0; i--) begin v[p] = fr[i]; p--; end
            kept = v[127:121];
            g = v[120];
            s = st;
            for (int i = 0; i < 120; i++) s = s | v[i];
            case (md)
                2'b01:   ulp = 1'b0;
                2'b10:   ulp = g | s;
                default: ulp = g & (s | kept[0]);
            endcase
            sum = {1'b0, kept} + {7'd0, ulp};
            r.inexact = g | s;
            if (sum[7]) begin
                mag = 7'h7F; r.sat = 1'b1;
            end else if (sum == 8'd0) begin
                mag = 7'h01; r.sat = 1'b1;
            end else begin
                mag = sum[6:0];
            end
        end
        pos = {1'b0, mag};
        r.posit = sg ? (8'd0 - pos) : pos;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pop/compare delivered beats, push expectations for accepted beats
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("stray_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("posit", {24'd0, out_posit}, {24'd0, e.posit});
                    check_val("inexact", {31'd0, out_inexact}, {31'd0, e.inexact});
                    check_val("sat", {31'd0, out_sat}, {31'd0, e.sat});
                    if (e.lat) check_val("latency", cyc - e.cyc, 32'd2);
                    if (e.inexact && exp_cnt < 65535) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_sign, in_nar, in_zero, int'($signed(in_k)), in_frac, in_sticky, in_mode);
                e.lat = lat_flag;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic sg, input logic nar, input logic zr, input int k,
                        input logic [7:0] fr, input logic st, input logic [1:0] md, input logic lat);
        logic hs;
        in_sign   = sg;
        in_nar    = nar;
        in_zero   = zr;
        in_k      = k[RS+1:0];
        in_frac   = fr;
        in_sticky = st;
        in_mode   = md;
        lat_flag  = lat;
        in_valid  = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                hs = 1'b1;
                break;
            end
        end
        if (!hs) check_val("handshake_timeout", {31'd0, hs}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat_flag = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_val("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    logic       rand_done;
    logic [7:0] cap;

    initial begin
        // reset state
        @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_posit", {24'd0, out_posit}, 32'd0);
        check_val("rst_cnt", {16'd0, inexact_cnt}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed scenarios
        send(0, 0, 0, 0, 8'h00, 0, 2'b00, 1);
        send(0, 0, 0, 0, 8'h04, 0, 2'b00, 0);
        send(0, 0, 0, 0, 8'h04, 0, 2'b01, 0);
        send(0, 0, 0, 0, 8'h04, 0, 2'b10, 0);
        send(0, 0, 0, 0, 8'h04, 0, 2'b11, 0);
        send(1, 0, 0, 0, 8'h80, 0, 2'b00, 0);
        send(0, 0, 0, 7, 8'h00, 0, 2'b00, 0);
        send(0, 0, 0, -10, 8'h00, 0, 2'b00, 0);
        send(0, 1, 1, 0, 8'h55, 1, 2'b10, 0);
        send(0, 0, 1, 0, 8'h55, 1, 2'b10, 0);
        send(0, 0, 0, 6, 8'h01, 0, 2'b10, 0);
        send(1, 0, 0, -6, 8'hC0, 1, 2'b00, 0);
        drain();
        check_val("cnt_directed", {16'd0, inexact_cnt}, exp_cnt);

        // clear while idle, then stall test
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check_val("cnt_clr", {16'd0, inexact_cnt}, 32'd0);

        out_ready = 1'b0;
        fork
            begin
                send(0, 0, 0, 1, 8'h04, 0, 2'b10, 0);
                send(1, 0, 0, 2, 8'h00, 0, 2'b00, 0);
                send(0, 0, 0, -2, 8'h3F, 1, 2'b00, 0);
                send(0, 0, 0, 0, 8'hA0, 0, 2'b01, 0);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check_val("stall_valid", {31'd0, out_valid}, 32'd1);
                cap = out_posit;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    check_val("stall_hold", {24'd0, out_posit}, {24'd0, cap});
                    check_val("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("cnt_stall", {16'd0, inexact_cnt}, exp_cnt);

        // random traffic with random back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send($urandom_range(0, 1), ($urandom_range(0, 15) == 0),
                         ($urandom_range(0, 15) == 0), int'($urandom_range(0, 18)) - 9,
                         8'($urandom_range(0, 255)), $urandom_range(0, 1),
                         2'($urandom_range(0, 3)), 0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("cnt_random", {16'd0, inexact_cnt}, exp_cnt);

        // clear takes priority over a simultaneous inexact delivery
        out_ready = 1'b0;
        send(0, 0, 0, 0, 8'h04, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check_val("clr_prio", {16'd0, inexact_cnt}, 32'd0);

        // one inexact beat so the counter is non-zero before reset
        send(0, 0, 0, 0, 8'h04, 0, 2'b00, 0);
        drain();
        check_val("cnt_pre_reset", {16'd0, inexact_cnt}, 32'd1);

        // reset with two beats in flight
        send(0, 0, 0, 1, 8'h0F, 1, 2'b00, 0);
        send(1, 0, 0, 2, 8'h33, 1, 2'b00, 0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check_val("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_flush_cnt", {16'd0, inexact_cnt}, 32'd0);
        check_val("rst_flush_posit", {24'd0, out_posit}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, 0, 0, -1, 8'h80, 0, 2'b00, 1);
        drain();
        check_val("cnt_post_reset", {16'd0, inexact_cnt}, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
